// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: shared widths, defaults and FSM state type for the framebuffer write scheduler
package fb_sched_pkg;
   localparam int FB_ADDR_W    = 18;
   localparam int FB_DATA_W    = 16;
   localparam int FB_WORDS_DEF = 76800;
   typedef enum logic [1:0] {S_RUN, S_CLR_WAIT, S_CLEAR} state_e;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous FIFO with combinational head and occupancy count
module pix_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 34,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   count_q, count_d;
   always_comb begin
      wr_d    = push ? wr_q + AW'(1) : wr_q;
      rd_d    = pop ? rd_q + AW'(1) : rd_q;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end
   assign head  = mem_q[rd_q];
   assign count = count_q;
   assign full  = count_q == (AW+1)'(DEPTH);
   assign empty = count_q == '0;
endmodule

// File: rtl/fb_write_sched.sv
// fb_write_sched: buffers rasterizer pixel writes and issues them, or a full clear,
// to the SRAM GPU port only while the video side is idle
module fb_write_sched
   import fb_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FB_WORDS   = FB_WORDS_DEF,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 I_CLK,
   input  logic                 I_RST_N,
   input  logic                 I_VIDEO_ON,
   input  logic                 I_PIX_VALID,
   input  logic [FB_ADDR_W-1:0] I_PIX_ADDR,
   input  logic [FB_DATA_W-1:0] I_PIX_DATA,
   output logic                 O_PIX_READY,
   input  logic                 I_CLEAR_REQ,
   input  logic [FB_DATA_W-1:0] I_CLEAR_COLOR,
   output logic [FB_ADDR_W-1:0] O_GPU_ADDR,
   output logic [FB_DATA_W-1:0] O_GPU_DATA,
   output logic                 O_GPU_WRITE,
   output logic                 O_GPU_READ,
   output logic                 O_BUSY,
   output logic                 O_CLEAR_DONE,
   output logic [CW-1:0]        O_FIFO_COUNT
);
   logic [FB_ADDR_W+FB_DATA_W-1:0] head;
   logic [CW-1:0]                  count, count_nx;
   logic                           full, empty, push, pop, fire, last;
   state_e                         state_q, state_d;
   logic [FB_ADDR_W-1:0]           clr_addr_q, clr_addr_d, addr_q, addr_d, src_addr;
   logic [FB_DATA_W-1:0]           color_q, color_d, data_q, data_d, src_data;
   logic                           ready_q, ready_d, done_q, done_d;
   always_comb begin
      push       = I_PIX_VALID & ready_q & ~full;
      fire       = (state_q == S_CLEAR | ~empty) & ~I_VIDEO_ON;
      pop        = fire & (state_q != S_CLEAR);
      src_addr   = state_q == S_CLEAR ? clr_addr_q : head[FB_ADDR_W+FB_DATA_W-1:FB_DATA_W];
      src_data   = state_q == S_CLEAR ? color_q : head[FB_DATA_W-1:0];
      addr_d     = fire ? src_addr : addr_q;
      data_d     = fire ? src_data : data_q;
      count_nx   = count + CW'(push) - CW'(pop);
      color_d    = (state_q == S_RUN & I_CLEAR_REQ) ? I_CLEAR_COLOR : color_q;
      last       = state_q == S_CLEAR & fire & clr_addr_q == FB_ADDR_W'(FB_WORDS - 1);
      clr_addr_d = state_q == S_CLEAR ? (fire ? clr_addr_q + FB_ADDR_W'(1) : clr_addr_q) : '0;
      // the clear may only start once every buffered pixel has reached SRAM
      state_d    = state_q == S_RUN      ? (I_CLEAR_REQ ? S_CLR_WAIT : S_RUN) :
                   state_q == S_CLR_WAIT ? (empty & ~fire ? S_CLEAR : S_CLR_WAIT) :
                                           (last ? S_RUN : S_CLEAR);
      done_d     = last;
      ready_d    = state_d == S_RUN & count_nx < CW'(FIFO_DEPTH);
   end
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q    <= S_RUN;
         clr_addr_q <= '0;
         color_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         color_q    <= color_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end
   pix_fifo #(.DEPTH(FIFO_DEPTH), .W(FB_ADDR_W + FB_DATA_W)) u_fifo (
      .clk   (I_CLK),
      .rst_n (I_RST_N),
      .push  (push),
      .pop   (pop),
      .din   ({I_PIX_ADDR, I_PIX_DATA}),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );
   assign O_PIX_READY  = ready_q;
   assign O_GPU_WRITE  = fire;
   assign O_GPU_ADDR   = addr_d;
   assign O_GPU_DATA   = data_d;
   assign O_GPU_READ   = 1'b0;
   assign O_BUSY       = ~empty | state_q != S_RUN;
   assign O_CLEAR_DONE = done_q;
   assign O_FIFO_COUNT = count;
endmodule

// File: tb/tb_fb_write_sched.sv
// tb_fb_write_sched: scoreboard bench; expected SRAM writes are queued as they are
// issued and a negedge monitor checks every GPU write and status output
module tb_fb_write_sched;
   localparam int DEPTH = 16;
   localparam int WORDS = 1500;
   logic        I_CLK = 0, I_RST_N = 0, I_VIDEO_ON = 0, I_PIX_VALID = 0, I_CLEAR_REQ = 0;
   logic [17:0] I_PIX_ADDR = 0;
   logic [15:0] I_PIX_DATA = 0, I_CLEAR_COLOR = 0;
   logic        O_PIX_READY, O_GPU_WRITE, O_GPU_READ, O_BUSY, O_CLEAR_DONE;
   logic [17:0] O_GPU_ADDR;
   logic [15:0] O_GPU_DATA;
   logic [4:0]  O_FIFO_COUNT;
   fb_write_sched #(.FIFO_DEPTH(DEPTH), .FB_WORDS(WORDS)) dut (
      .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VIDEO_ON(I_VIDEO_ON),
      .I_PIX_VALID(I_PIX_VALID), .I_PIX_ADDR(I_PIX_ADDR), .I_PIX_DATA(I_PIX_DATA),
      .O_PIX_READY(O_PIX_READY), .I_CLEAR_REQ(I_CLEAR_REQ), .I_CLEAR_COLOR(I_CLEAR_COLOR),
      .O_GPU_ADDR(O_GPU_ADDR), .O_GPU_DATA(O_GPU_DATA), .O_GPU_WRITE(O_GPU_WRITE),
      .O_GPU_READ(O_GPU_READ), .O_BUSY(O_BUSY), .O_CLEAR_DONE(O_CLEAR_DONE),
      .O_FIFO_COUNT(O_FIFO_COUNT)
   );
   always #5 I_CLK = ~I_CLK;
   typedef struct { logic [17:0] a; logic [15:0] d; bit clr; bit last; } ent_t;
   ent_t        q[$];
   int          n_cmp = 0, n_bad = 0, pend = 0, done_cnt = 0, clr_wr = 0, cyc = 0;
   bit          active = 0, done_due = 0, stream_done = 0;
   logic [17:0] last_a = 0;
   logic [15:0] last_d = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tmo(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask
   always @(posedge I_CLK or negedge I_RST_N)
      if (!I_RST_N) cyc <= 0;
      else if (cyc < 2) cyc <= cyc + 1;
   // reference model: a write queue in SRAM order plus a clear-in-progress flag
   always @(negedge I_CLK) begin
      ent_t e;
      bit   acc;
      if (!I_RST_N) begin
         q.delete();
         pend = 0; active = 0; done_due = 0; last_a = 0; last_d = 0;
      end else begin
         chk("fifo_count", 32'(O_FIFO_COUNT), 32'(pend));
         chk("pix_ready", 32'(O_PIX_READY), 32'(cyc >= 1 && !active && pend < DEPTH));
         chk("busy", 32'(O_BUSY), 32'(pend != 0 || active));
         if (O_CLEAR_DONE || done_due) chk("clear_done", 32'(O_CLEAR_DONE), 32'(done_due));
         done_cnt += int'(O_CLEAR_DONE);
         done_due = 0;
         acc = I_CLEAR_REQ && !active;
         if (O_GPU_WRITE) begin
            if (I_VIDEO_ON) chk("write_in_video", 32'(O_GPU_WRITE), 0);
            if (q.size() == 0) chk("unexpected_write", 32'(O_GPU_ADDR), 32'h3ffff);
            else begin
               e = q.pop_front();
               chk("wr_addr", 32'(O_GPU_ADDR), 32'(e.a));
               chk("wr_data", 32'(O_GPU_DATA), 32'(e.d));
               if (e.clr) clr_wr++; else pend--;
               if (e.last) begin active = 0; done_due = 1; end
               last_a = e.a; last_d = e.d;
            end
         end else begin
            chk("hold_addr", 32'(O_GPU_ADDR), 32'(last_a));
            chk("hold_data", 32'(O_GPU_DATA), 32'(last_d));
         end
         if (I_PIX_VALID && O_PIX_READY) begin
            q.push_back('{I_PIX_ADDR, I_PIX_DATA, 0, 0});
            pend++;
         end
         if (acc) begin
            for (int i = 0; i < WORDS; i++) q.push_back('{18'(i), I_CLEAR_COLOR, 1, i == WORDS - 1});
            active = 1;
         end
      end
   end
   task automatic cyc1(); @(posedge I_CLK); #1; endtask
   task automatic ns(); @(negedge I_CLK); #1; endtask
   task automatic push_pix(input logic [17:0] a, input logic [15:0] d);
      bit acc = 0;
      I_PIX_VALID = 1; I_PIX_ADDR = a; I_PIX_DATA = d;
      for (int i = 0; i < 200 && !acc; i++) begin ns(); acc = O_PIX_READY; cyc1(); end
      if (!acc) tmo("push");
   endtask
   task automatic wait_idle(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin ns(); ok = q.size() == 0 && !active && !done_due; end
      if (!ok) tmo("idle");
      cyc1();
   endtask
   task automatic wait_clr(input logic [17:0] a);
      bit ok = 0;
      for (int i = 0; i < WORDS + 300 && !ok; i++) begin ns(); ok = O_GPU_WRITE && O_GPU_ADDR == a && active; end
      if (!ok) tmo("clear_addr");
   endtask
   task automatic pulse_clear(input logic [15:0] c);
      I_CLEAR_REQ = 1; I_CLEAR_COLOR = c;
      cyc1();
      I_CLEAR_REQ = 0; I_CLEAR_COLOR = 16'($urandom);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int d0, c0;
      logic [17:0] a17;
      logic [15:0] d17;
      logic [17:0] ta [3];
      logic [15:0] td [3];
      ta = '{18'h10, 18'h11, 18'h12};
      td = '{16'hF00F, 16'h0F0F, 16'h00FF};
      repeat (3) cyc1();
      I_RST_N = 1;
      ns();
      chk("rst_ready", 32'(O_PIX_READY), 0);
      chk("rst_write", 32'(O_GPU_WRITE), 0);
      chk("rst_addr", 32'(O_GPU_ADDR), 0);
      chk("rst_data", 32'(O_GPU_DATA), 0);
      chk("rst_count", 32'(O_FIFO_COUNT), 0);
      cyc1();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin I_PIX_VALID = 1; I_PIX_ADDR = ta[i]; I_PIX_DATA = td[i]; end
         else I_PIX_VALID = 0;
         ns();
         if (i > 0) begin
            chk("lat_write", 32'(O_GPU_WRITE), 1);
            chk("lat_addr", 32'(O_GPU_ADDR), 32'(ta[i-1]));
            chk("lat_data", 32'(O_GPU_DATA), 32'(td[i-1]));
         end
         cyc1();
      end
      ns();
      chk("drained_count", 32'(O_FIFO_COUNT), 0);
      cyc1();
      I_VIDEO_ON = 1;
      for (int i = 0; i < 16; i++) push_pix(18'($urandom), 16'($urandom));
      a17 = 18'($urandom); d17 = 16'($urandom);
      I_PIX_ADDR = a17; I_PIX_DATA = d17;
      repeat (4) begin
         ns();
         chk("full_ready", 32'(O_PIX_READY), 0);
         chk("full_count", 32'(O_FIFO_COUNT), 16);
         chk("full_nowrite", 32'(O_GPU_WRITE), 0);
         cyc1();
      end
      I_VIDEO_ON = 0;
      push_pix(a17, d17);
      I_PIX_VALID = 0;
      wait_idle(100);
      stream_done = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) push_pix(18'($urandom), 16'($urandom));
            I_PIX_VALID = 0;
            stream_done = 1;
         end
         while (!stream_done) begin repeat (3) cyc1(); I_VIDEO_ON = ~I_VIDEO_ON; end
      join
      I_VIDEO_ON = 0;
      wait_idle(200);
      d0 = done_cnt; c0 = clr_wr;
      I_VIDEO_ON = 1;
      for (int i = 0; i < 5; i++) push_pix(18'($urandom), 16'($urandom));
      I_PIX_VALID = 0;
      pulse_clear(16'h0000);
      repeat (3) cyc1();
      I_VIDEO_ON = 0;
      wait_idle(WORDS + 200);
      chk("clr1_done_cnt", 32'(done_cnt - d0), 1);
      chk("clr1_words", 32'(clr_wr - c0), WORDS);
      ns();
      chk("clr1_ready_back", 32'(O_PIX_READY), 1);
      cyc1();
      d0 = done_cnt; c0 = clr_wr;
      pulse_clear(16'($urandom));
      wait_clr(18'd1000);
      cyc1();
      I_RST_N = 0;
      #1;
      chk("arst_write", 32'(O_GPU_WRITE), 0);
      chk("arst_addr", 32'(O_GPU_ADDR), 0);
      chk("arst_data", 32'(O_GPU_DATA), 0);
      chk("arst_ready", 32'(O_PIX_READY), 0);
      chk("arst_busy", 32'(O_BUSY), 0);
      chk("arst_done", 32'(O_CLEAR_DONE), 0);
      chk("arst_read", 32'(O_GPU_READ), 0);
      ns();
      cyc1();
      I_RST_N = 1;
      repeat (50) cyc1();
      chk("arst_words", 32'(clr_wr - c0), 1001);
      chk("arst_no_done", 32'(done_cnt - d0), 0);
      d0 = done_cnt; c0 = clr_wr;
      pulse_clear(16'($urandom));
      wait_clr(18'd200);
      cyc1();
      pulse_clear(16'($urandom));
      wait_idle(WORDS + 200);
      chk("clr2_done_cnt", 32'(done_cnt - d0), 1);
      chk("clr2_words", 32'(clr_wr - c0), WORDS);
      repeat (5) cyc1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fb_write_sched.md
# fb_write_sched

Framebuffer write scheduler between the Rasterizer pixel stream and the GPU port of MultiSram. It buffers incoming pixel writes in a small FIFO. Writes are issued to SRAM only while the VGA side is not reading (I_VIDEO_ON low). It also sequences a full-framebuffer clear on request, and orders that clear correctly against buffered pixels.

## Interface
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, ≥2
- FB_WORDS, 76800, framebuffer words cleared by a clear request; ≤ 2^18
- I_CLK  in  1  pll_c0 domain clock
- I_RST_N  in  1  asynchronous, active-low reset
- I_VIDEO_ON  in  1  high = VGA owns SRAM; no GPU access allowed
- I_PIX_VALID  in  1  rasterizer offers a pixel write
- I_PIX_ADDR  in  18  pixel word address
- I_PIX_DATA  in  16  pixel color
- O_PIX_READY  out  1  registered; a push occurs when I_PIX_VALID & O_PIX_READY
- I_CLEAR_REQ  in  1  single-cycle clear request
- I_CLEAR_COLOR  in  16  fill value, sampled with I_CLEAR_REQ
- O_GPU_ADDR  out  18  to MultiSram I_GPU_ADDR
- O_GPU_DATA  out  16  to MultiSram I_GPU_DATA
- O_GPU_WRITE  out  1  to MultiSram I_GPU_WRITE
- O_GPU_READ  out  1  tied 0
- O_BUSY  out  1  FIFO non-empty or a clear is pending/active
- O_CLEAR_DONE  out  1  one-cycle pulse after the last clear write
- O_FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- States: S_RUN, S_CLR_WAIT, S_CLEAR.
- S_RUN
  - Accept pushes while not full.
  - Drain the FIFO head.
  - I_CLEAR_REQ latches the color and moves to S_CLR_WAIT.
- S_CLR_WAIT
  - O_PIX_READY is forced low.
  - The FIFO keeps draining.
  - When count == 0 and no write fires this cycle, go to S_CLEAR with clr_addr = 0.
- S_CLEAR
  - Each fire writes the latched color to clr_addr, then clr_addr increments.
  - The fire at clr_addr == FB_WORDS-1 returns to S_RUN and pulses O_CLEAR_DONE on the next cycle.
  - O_PIX_READY stays low throughout.
- I_CLEAR_REQ in S_CLR_WAIT or S_CLEAR is ignored; there is no queueing.
- Fire condition (combinational):
  - fire = source_valid & ~I_VIDEO_ON.
  - source_valid is count ≠ 0 in S_RUN/S_CLR_WAIT and 1 in S_CLEAR.
  - O_GPU_WRITE = fire.
  - O_GPU_ADDR/O_GPU_DATA come from the FIFO head (or clr_addr/color in S_CLEAR).
  - Outside a fire they hold the last driven values.
- Pop happens only on fire in S_RUN/S_CLR_WAIT. A write is never issued and then lost.
- Push and pop in the same cycle leave the count unchanged. Write order in SRAM equals push order.
- O_PIX_READY next value: 1 iff next state is S_RUN and count_next < FIFO_DEPTH. Push in the same cycle is accounted for, so no overflow is possible.
- Read/write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Count is one bit wider to distinguish full from empty.

## Timing
- Reset values:
  - O_PIX_READY = 0, O_GPU_WRITE = 0, O_GPU_ADDR = 0, O_GPU_DATA = 0.
  - O_BUSY = 0, O_CLEAR_DONE = 0, O_FIFO_COUNT = 0.
  - State S_RUN, pointers 0.
- Reset asserted mid-clear or with the FIFO non-empty:
  - Everything returns to reset values immediately.
  - Buffered pixels and clear progress are discarded.
- O_PIX_READY rises in the first cycle after reset release.
- Latency, push to O_GPU_WRITE: 1 cycle minimum (FIFO empty, I_VIDEO_ON low).
- Throughput: one write per cycle while I_VIDEO_ON is low. I_VIDEO_ON high stalls all writes with zero loss.
- A full clear takes FB_WORDS non-video cycles plus the drain time.
- O_CLEAR_DONE is asserted exactly one cycle after the final clear fire.

## Structure
- Shared package `fb_sched_pkg`:
  - state enum (S_RUN, S_CLR_WAIT, S_CLEAR)
  - FB_ADDR_W = 18
  - FB_DATA_W = 16
  - FB_WORDS default
- One sub-module `pix_fifo`:
  - Parameterised synchronous FIFO.
  - Head available combinationally.
  - Ports: push, pop, din, head, count, full, empty.
- The FSM, clear counter and fire logic live in fb_write_sched.

## Test plan
- Reset, then push 3 pixels (addr 0x10/0x11/0x12, data 0xF00F/0x0F0F/0x00FF) with I_VIDEO_ON = 0. Required: O_GPU_WRITE high for 3 cycles starting 1 cycle after the first push, in order, with count back to 0.
- I_VIDEO_ON = 1 while pushing 16 pixels. Required: O_PIX_READY drops once count reaches 16, no O_GPU_WRITE, and a 17th offer is held. After I_VIDEO_ON drops, 16 writes occur in order and the held pixel is accepted.
- Toggle I_VIDEO_ON every 3 cycles while streaming 100 pixels. Required: O_GPU_WRITE is never high with I_VIDEO_ON high, and all 100 writes appear in order exactly once.
- With 5 pixels buffered, pulse I_CLEAR_REQ (color 0x0000). Required: the 5 pixels are written first and O_PIX_READY stays low. Then addresses 0..FB_WORDS-1 are written with 0x0000, O_CLEAR_DONE pulses once, and O_PIX_READY returns.
- Assert I_RST_N low at clear address 1000. Required: all outputs go to reset values asynchronously, and after release no further clear writes occur.
- Pulse I_CLEAR_REQ again during S_CLEAR. Required: it is ignored, there is exactly one O_CLEAR_DONE, and there are exactly FB_WORDS clear writes.
